mux_tree_pipe: RTL and testbench
================================

# mux_tree_pipe

Parametrised, pipelined N:1 selector tree that generalises the fixed 32:1 single-bit register-file read mux to arbitrary data width, input count and pipeline depth. The block uses a valid/ready handshake with backpressure and a synchronous flush. It sits in front of wide read paths, such as register-file read ports and forwarding selects, where a single-cycle 5-level mux breaks timing. Each group of tree levels is registered, and the select bits still needed travel with the data.

## Interface
- WIDTH, 32: bits per input word.
- N_IN, 32: number of inputs. Must be a power of two, at least 2.
- SEL_W, $clog2(N_IN): select width. Derived; not overridden.
- REG_EVERY, 1: tree levels per pipeline stage. Must divide SEL_W.
- Clock and reset: one clock; reset is asynchronous and active-low.
- CLK  input  1  clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- FLUSH  input  1  synchronous clear of all in-flight entries.
- IN  input  N_IN*WIDTH  flattened inputs; input i is IN[i*WIDTH +: WIDTH].
- SEL  input  SEL_W  index of the input to forward.
- IN_VALID  input  1  IN/SEL valid this cycle.
- IN_READY  output  1  block accepts IN/SEL this cycle.
- OUT  output  WIDTH  selected word.
- OUT_VALID  output  1  OUT holds a valid result.
- OUT_READY  input  1  downstream accepts OUT this cycle.

## Operation
- Tree level l (l = 0 … SEL_W-1) halves the candidate set using SEL[l]. Level 0 takes the LSB and pairs adjacent inputs. This matches the existing mux_16/mux_2 composition, where SEL[4] drives the final 2:1.
- NSTG = SEL_W / REG_EVERY stages. Stage k evaluates levels k*REG_EVERY … (k+1)*REG_EVERY-1 combinationally, then registers three things:
  - surviving candidates: N_IN >> ((k+1)*REG_EVERY) words;
  - the unused upper SEL bits;
  - a valid bit.
- The last stage register is OUT. OUT is always registered; there is no combinational path from IN to OUT.
- Handshake, per stage k:
  - ready[k] = !valid[k] || ready[k+1], with ready[NSTG] = OUT_READY.
  - IN_READY = ready[0].
  - A transfer into stage k happens when its upstream valid and ready[k] are both 1.
  - A stage with valid=1 and ready=0 holds data, SEL remainder and valid unchanged.
- The ready chain is combinational from OUT_READY to IN_READY. Full throughput is 1 word/cycle with no bubbles while OUT_READY=1.
- FLUSH=1 at a rising edge clears every stage valid. Any IN accepted in that same cycle is discarded. FLUSH takes priority over any transfer. Data registers need not clear.
- IN_VALID=0 pushes a bubble (valid=0) into stage 0 when ready[0]=1.
- SEL is interpreted unsigned. Every index 0 … N_IN-1 is legal; there is no out-of-range case.

## Timing
- Latency: a word accepted at edge t appears on OUT with OUT_VALID=1 after edge t+NSTG-1, when there is no backpressure. With N_IN=32 and REG_EVERY=1 that is 5 edges; with REG_EVERY=5 it is 1.
- Reset (RST_N=0, asynchronous): all stage valids, OUT_VALID and OUT go to 0. IN_READY becomes 1 once valids are clear.
- Reset mid-operation: all in-flight entries are lost and no partial result appears. The first accepted word after RST_N rises returns after the normal latency.
- Full pipeline with OUT_READY=0: IN_READY=0. The first cycle OUT_READY=1, IN_READY=1 in the same cycle, so the pipeline advances one stage with no lost or duplicated word.
- Simultaneous FLUSH and OUT_READY=1 with OUT_VALID=1: that output does count as consumed by downstream, and OUT_VALID=0 on the next cycle.

## Structure
- The shared header proc_defs.vh holds the codebase default data width (32) and register count (32) used as WIDTH and N_IN defaults. No new typedefs.
- Sub-module mux_pipe_stage:
  - parameters: WIDTH, N_CAND, LEVELS, SEL_REM;
  - contents: LEVELS mux levels, candidate/SEL/valid registers, local ready logic.
- mux_tree_pipe is a generate loop of NSTG mux_pipe_stage instances.

## Test plan
- Reset: hold RST_N=0 with IN_VALID=1. Required: OUT=0, OUT_VALID=0, with no transfers. Release RST_N, then IN_READY=1.
- Sweep, N_IN=32, WIDTH=32, REG_EVERY=1, IN[i]=32'hA000_0000+i, OUT_READY=1: SEL=0…31 on consecutive cycles. Required: OUT=A000_0000…A000_001F, starting 5 edges after the first accept, one per cycle.
- Backpressure: stream SEL=3,7,31 and hold OUT_READY=0 for 8 cycles. Required: IN_READY drops to 0 once all 5 stages are valid, and OUT holds the SEL=3 word. Release OUT_READY: words for 3, 7, 31 come out in order, with no duplicates or drops.
- Flush: with 3 words in flight, assert FLUSH for 1 cycle together with a new IN_VALID (SEL=9). Required: OUT_VALID=0 for the following 5 cycles, and SEL=9 never appears.
- Mid-operation reset: pulse RST_N low between edges with the pipeline full. Required: OUT_VALID and OUT fall to 0 immediately (asynchronously). The next accepted SEL=1 returns IN[1] after 5 edges.
- Config N_IN=4, WIDTH=8, REG_EVERY=2: with IN={8'h44,8'h33,8'h22,8'h11} (IN[0]=8'h11), SEL=2 → OUT=8'h33 after 1 edge.

Source files
------------

// File: rtl/mux_tree_pipe_pkg.sv
// mux_tree_pipe_pkg: codebase default data width/register count and helper for the select-remainder width carried between stages
package mux_tree_pipe_pkg;
  localparam int DATA_W = 32;
  localparam int N_REGS = 32;
  function automatic int rem_w(int sel_rem, int levels);
    return sel_rem > levels ? sel_rem - levels : 1;
  endfunction
endpackage

// File: rtl/mux_pipe_stage.sv
// mux_pipe_stage: LEVELS mux levels then candidate/select-remainder/valid registers; up_* = upstream side (up_ready out), dn_* = registered side (dn_ready in)
module mux_pipe_stage
  import mux_tree_pipe_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int N_CAND = N_REGS,
  parameter int LEVELS = 1,
  parameter int SEL_REM = $clog2(N_CAND),
  localparam int N_OUT = N_CAND >> LEVELS,
  localparam int SO = rem_w(SEL_REM, LEVELS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [N_CAND*WIDTH-1:0] up_cand,
  input  logic [SEL_REM-1:0]      up_sel,
  input  logic                    up_valid,
  output logic                    up_ready,
  output logic [N_OUT*WIDTH-1:0]  dn_cand,
  output logic [SO-1:0]           dn_sel,
  output logic                    dn_valid,
  input  logic                    dn_ready
);
  for (genvar l = 0; l <= LEVELS; l++) begin : g_l
    logic [(N_CAND >> l)*WIDTH-1:0] c;
    if (l == 0) begin : g_in
      assign c = up_cand;
    end else begin : g_mx
      for (genvar j = 0; j < (N_CAND >> l); j++) begin : g_j
        assign c[j*WIDTH +: WIDTH] = up_sel[l-1] ? g_l[l-1].c[(2*j+1)*WIDTH +: WIDTH]
                                                 : g_l[l-1].c[2*j*WIDTH +: WIDTH];
      end
    end
  end
  logic [SO-1:0] sel_nx;
  if (SEL_REM > LEVELS) begin : g_rem
    assign sel_nx = up_sel[SEL_REM-1:LEVELS];
  end else begin : g_none
    assign sel_nx = '0;
  end
  assign up_ready = !dn_valid || dn_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_cand  <= '0;
      dn_sel   <= '0;
    end else begin
      dn_valid <= flush ? 1'b0 : up_ready ? up_valid : dn_valid;
      if (up_ready && up_valid) begin
        dn_cand <= g_l[LEVELS].c;
        dn_sel  <= sel_nx;
      end
    end
endmodule

// File: rtl/mux_tree_pipe.sv
// mux_tree_pipe: pipelined N_IN:1 selector with valid/ready and flush; in/sel/in_valid/in_ready upstream, out/out_valid/out_ready downstream
module mux_tree_pipe
  import mux_tree_pipe_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int N_IN = N_REGS,
  parameter int REG_EVERY = 1,
  localparam int SEL_W = $clog2(N_IN),
  localparam int NSTG = SEL_W / REG_EVERY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [N_IN*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out,
  output logic                  out_valid,
  input  logic                  out_ready
);
  for (genvar k = 0; k < NSTG; k++) begin : g_s
    localparam int CI = N_IN >> (k*REG_EVERY);
    localparam int SR = SEL_W - k*REG_EVERY;
    logic [CI*WIDTH-1:0]                 u_cand;
    logic [SR-1:0]                       u_sel;
    logic                                u_valid;
    logic                                d_ready;
    logic [(CI >> REG_EVERY)*WIDTH-1:0]  s_cand;
    logic [rem_w(SR, REG_EVERY)-1:0]     s_sel;
    logic                                s_valid;
    logic                                s_ready;
    if (k == 0) begin : g_head
      assign u_cand  = in;
      assign u_sel   = sel;
      assign u_valid = in_valid;
    end else begin : g_link
      assign u_cand  = g_s[k-1].s_cand;
      assign u_sel   = g_s[k-1].s_sel;
      assign u_valid = g_s[k-1].s_valid;
    end
    if (k == NSTG-1) begin : g_tail
      assign d_ready = out_ready;
    end else begin : g_next
      assign d_ready = g_s[k+1].s_ready;
    end
    mux_pipe_stage #(
      .WIDTH(WIDTH), .N_CAND(CI), .LEVELS(REG_EVERY), .SEL_REM(SR)
    ) u_stage (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .up_cand(u_cand), .up_sel(u_sel), .up_valid(u_valid), .up_ready(s_ready),
      .dn_cand(s_cand), .dn_sel(s_sel), .dn_valid(s_valid), .dn_ready(d_ready)
    );
  end
  logic sel_unused;
  assign sel_unused = ^g_s[NSTG-1].s_sel;
  assign in_ready   = g_s[0].s_ready;
  assign out        = g_s[NSTG-1].s_cand;
  assign out_valid  = g_s[NSTG-1].s_valid;
endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb_mux_tree_pipe: directed and randomized checks of a 32x32/5-stage and an 4x8/1-stage mux_tree_pipe against a queue model
module tb_mux_tree_pipe;
  logic clk = 1'b0;
  logic rst_n, flush;
  logic [1023:0] a_in;
  logic [4:0]    a_sel;
  logic          a_iv, a_ir, a_ov, a_or;
  logic [31:0]   a_out;
  logic [31:0]   b_in;
  logic [1:0]    b_sel;
  logic          b_iv, b_ir, b_ov, b_or;
  logic [7:0]    b_out;
  int checks = 0, errors = 0;
  logic [31:0] qa[$];
  logic [7:0]  qb[$];
  always #5 clk = ~clk;
  mux_tree_pipe #(.WIDTH(32), .N_IN(32), .REG_EVERY(1)) d32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in(a_in), .sel(a_sel), .in_valid(a_iv),
    .in_ready(a_ir), .out(a_out), .out_valid(a_ov), .out_ready(a_or)
  );
  mux_tree_pipe #(.WIDTH(8), .N_IN(4), .REG_EVERY(2)) d4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in(b_in), .sel(b_sel), .in_valid(b_iv),
    .in_ready(b_ir), .out(b_out), .out_valid(b_ov), .out_ready(b_or)
  );
  task automatic set_ramp();
    for (int i = 0; i < 32; i++) a_in[i*32 +: 32] = 32'hA000_0000 + i;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; set_ramp();
    a_iv = 1'b1; a_sel = 5'd3; a_or = 1'b1;
    b_in = 32'h4433_2211; b_iv = 1'b1; b_sel = 2'd2; b_or = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a_out !== 32'h0) begin errors++; $display("FAIL reset_a_out: got %h want 0", a_out); end
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL reset_a_ov: got %b want 0", a_ov); end
    checks++; if (b_out !== 8'h0) begin errors++; $display("FAIL reset_b_out: got %h want 0", b_out); end
    checks++; if (b_ov !== 1'b0) begin errors++; $display("FAIL reset_b_ov: got %b want 0", b_ov); end
    a_iv = 1'b0; b_iv = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL reset_a_ir: got %b want 1", a_ir); end
    checks++; if (b_ir !== 1'b1) begin errors++; $display("FAIL reset_b_ir: got %b want 1", b_ir); end
    repeat (6) @(posedge clk);
    #1;
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL reset_idle_a_ov: got %b want 0", a_ov); end
    checks++; if (b_ov !== 1'b0) begin errors++; $display("FAIL reset_idle_b_ov: got %b want 0", b_ov); end
  endtask
  task automatic test_sweep();
    logic ev;
    a_or = 1'b1;
    for (int c = 0; c < 37; c++) begin
      a_iv = c < 32;
      a_sel = 5'(c);
      @(posedge clk);
      #1;
      ev = c >= 4 && c < 36;
      checks++; if (a_ov !== ev) begin errors++; $display("FAIL sweep_valid c=%0d: got %b want %b", c, a_ov, ev); end
      if (ev) begin
        checks++;
        if (a_out !== 32'hA000_0000 + c - 4) begin errors++; $display("FAIL sweep_out c=%0d: got %h want %h", c, a_out, 32'hA000_0000 + c - 4); end
      end
    end
  endtask
  task automatic test_backpressure();
    logic [4:0] seq [6] = '{5'd3, 5'd7, 5'd31, 5'd12, 5'd20, 5'd5};
    logic [31:0] exp[$];
    logic [31:0] e;
    int n = 0, got = 0;
    a_or = 1'b0;
    for (int c = 0; c < 8; c++) begin
      a_iv = n < 6; a_sel = seq[n < 6 ? n : 0];
      #1;
      checks++; if (a_ir !== (n < 5)) begin errors++; $display("FAIL bp_in_ready c=%0d: got %b want %b", c, a_ir, n < 5); end
      if (a_iv && a_ir) begin exp.push_back(32'hA000_0000 + seq[n]); n++; end
      @(posedge clk);
      #1;
    end
    checks++; if (n !== 5) begin errors++; $display("FAIL bp_accepts: got %0d want 5", n); end
    checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b want 1", a_ov); end
    checks++; if (a_out !== 32'hA000_0003) begin errors++; $display("FAIL bp_hold_out: got %h want a0000003", a_out); end
    a_or = 1'b1;
    #1;
    checks++; if (a_ir !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", a_ir); end
    for (int c = 0; c < 20; c++) begin
      a_iv = n < 6; a_sel = seq[n < 6 ? n : 0];
      #1;
      if (a_ov && a_or) begin
        checks++;
        e = exp.size() != 0 ? exp.pop_front() : 32'hx;
        if (a_out !== e) begin errors++; $display("FAIL bp_drain #%0d: got %h want %h", got, a_out, e); end
        got++;
      end
      if (a_iv && a_ir) begin exp.push_back(32'hA000_0000 + seq[n]); n++; end
      @(posedge clk);
      #1;
    end
    checks++; if (got !== 6 || exp.size() != 0) begin errors++; $display("FAIL bp_count: got %0d words, %0d left, want 6 and 0", got, exp.size()); end
  endtask
  task automatic test_flush();
    for (int p = 0; p < 2; p++) begin
      a_or = 1'b1;
      for (int i = 0; i < (p == 0 ? 3 : 6); i++) begin
        a_iv = 1'b1; a_sel = 5'(i + 1);
        @(posedge clk);
        #1;
      end
      if (p == 1) begin
        checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %b want 1", a_ov); end
      end
      flush = 1'b1; a_iv = 1'b1; a_sel = 5'd9;
      @(posedge clk);
      #1;
      flush = 1'b0; a_iv = 1'b0;
      for (int c = 0; c < 8; c++) begin
        checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL flush_valid p=%0d c=%0d: got %b (out %h) want 0", p, c, a_ov, a_out); end
        @(posedge clk);
        #1;
      end
    end
  endtask
  task automatic test_midreset();
    logic ev;
    a_or = 1'b0; a_iv = 1'b1; a_sel = 5'd4;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (a_ov !== 1'b1) begin errors++; $display("FAIL midrst_full: got %b want 1", a_ov); end
    rst_n = 1'b0;
    #1;
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL midrst_async_valid: got %b want 0", a_ov); end
    checks++; if (a_out !== 32'h0) begin errors++; $display("FAIL midrst_async_out: got %h want 0", a_out); end
    rst_n = 1'b1; a_iv = 1'b1; a_sel = 5'd1; a_or = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      a_iv = 1'b0;
      ev = c == 4;
      checks++; if (a_ov !== ev) begin errors++; $display("FAIL midrst_lat c=%0d: got %b want %b", c, a_ov, ev); end
    end
    checks++; if (a_out !== 32'hA000_0001) begin errors++; $display("FAIL midrst_out: got %h want a0000001", a_out); end
  endtask
  task automatic test_config4();
    logic [1:0] s [5] = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [7:0] e;
    b_in = {8'h44, 8'h33, 8'h22, 8'h11}; b_or = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_iv = 1'b1; b_sel = s[i];
      e = 8'h11 * (8'(s[i]) + 8'd1);
      @(posedge clk);
      #1;
      b_iv = 1'b0;
      checks++; if (b_ov !== 1'b1) begin errors++; $display("FAIL cfg4_valid sel=%0d: got %b want 1", s[i], b_ov); end
      checks++; if (b_out !== e) begin errors++; $display("FAIL cfg4_out sel=%0d: got %h want %h", s[i], b_out, e); end
    end
    @(posedge clk);
    #1;
    checks++; if (b_ov !== 1'b0) begin errors++; $display("FAIL cfg4_drain: got %b want 0", b_ov); end
  endtask
  task automatic test_random();
    logic [31:0] ea;
    logic [7:0] eb;
    flush = 1'b1; a_iv = 1'b0; b_iv = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b0;
    qa.delete(); qb.delete();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 32; i++) a_in[i*32 +: 32] = $urandom;
      a_sel = 5'($urandom); a_iv = $urandom_range(0, 3) != 0; a_or = $urandom_range(0, 3) != 0;
      b_in = $urandom; b_sel = 2'($urandom); b_iv = $urandom_range(0, 3) != 0; b_or = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 29) == 0;
      #1;
      checks++; if (a_ir !== (a_or || qa.size() < 5)) begin errors++; $display("FAIL rnd_a_ready c=%0d: got %b want %b", c, a_ir, a_or || qa.size() < 5); end
      checks++; if (b_ir !== (b_or || qb.size() < 1)) begin errors++; $display("FAIL rnd_b_ready c=%0d: got %b want %b", c, b_ir, b_or || qb.size() < 1); end
      checks++; if (a_ov && qa.size() == 0) begin errors++; $display("FAIL rnd_a_phantom c=%0d: got valid %h want none", c, a_out); end
      checks++; if (b_ov && qb.size() == 0) begin errors++; $display("FAIL rnd_b_phantom c=%0d: got valid %h want none", c, b_out); end
      if (a_ov && a_or && qa.size() != 0) begin
        ea = qa.pop_front();
        checks++; if (a_out !== ea) begin errors++; $display("FAIL rnd_a_out c=%0d: got %h want %h", c, a_out, ea); end
      end
      if (b_ov && b_or && qb.size() != 0) begin
        eb = qb.pop_front();
        checks++; if (b_out !== eb) begin errors++; $display("FAIL rnd_b_out c=%0d: got %h want %h", c, b_out, eb); end
      end
      if (flush) begin
        qa.delete(); qb.delete();
      end else begin
        if (a_iv && a_ir) qa.push_back(a_in[a_sel*32 +: 32]);
        if (b_iv && b_ir) qb.push_back(b_in[b_sel*8 +: 8]);
      end
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
  endtask
  initial begin
    test_reset();
    test_sweep();
    test_backpressure();
    test_flush();
    test_midreset();
    test_config4();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
